// File: rtl/even_cnt_sched.sv
// rtl/even_cnt_sched.sv - round-robin scheduler sharing one even-step counter between two requesters
//
// Purpose:
//    Grants one of two requesters, drives the shared counter's run input for the
//    granted step count, then pulses done. Ties alternate. Jobs abort early when the
//    granted request drops. The counter value is also monitored for a 14->0 wrap
//    under this block's run and for illegal odd values.
//
// Ports:
//    clk      in   clock, rising edge
//    rst      in   reset, asynchronous, active-low
//    req0/1   in   level requests, held until the matching done
//    steps0/1 in   requested step count, sampled while the matching gnt is high
//    cnt_in   in   current value of the shared even-step counter
//    gnt0/1   out  1-cycle grant pulses
//    done0/1  out  1-cycle job-finished pulses
//    aborted  out  high with done when the job ended because its request dropped
//    run      out  run/enable to the shared counter
//    busy     out  high in every state except IDLE
//    wrap     out  1-cycle pulse after run=1 and cnt_in==14 are sampled together
//    err      out  sticky: cnt_in was seen odd

module even_cnt_sched #(
   parameter int STEP_W     = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [STEP_W-1:0] steps0,
   input  logic              req1,
   input  logic [STEP_W-1:0] steps1,
   input  logic [3:0]        cnt_in,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic              aborted,
   output logic              run,
   output logic              busy,
   output logic              wrap,
   output logic              err
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, GAP} state_t;

   localparam logic [STEP_W-1:0] REM_ONE  = STEP_W'(1);
   localparam logic [3:0]        GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t            state_q, state_d;
   logic              sel_q, sel_d;     // requester owning the current job
   logic              last_q, last_d;   // requester served most recently
   logic [STEP_W-1:0] remaining_q, remaining_d;
   logic [3:0]        gap_q, gap_d;
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              done0_q, done0_d, done1_q, done1_d;
   logic              aborted_q, aborted_d;
   logic              run_q, run_d, busy_q, busy_d;
   logic              wrap_q, wrap_d, err_q, err_d;

   logic              req_sel;
   logic [STEP_W-1:0] steps_sel;
   logic              abort_now;

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_d      = last_q;
      remaining_d = remaining_q;
      gap_d       = gap_q;
      abort_now   = 1'b0;
      req_sel     = sel_q ? req1 : req0;
      steps_sel   = sel_q ? steps1 : steps0;

      case (state_q)
         IDLE: begin
            // On a tie the requester not served last wins, giving strict alternation.
            if (req0 && req1) begin
               sel_d   = ~last_q;
               state_d = LOAD;
            end else if (req0) begin
               sel_d   = 1'b0;
               state_d = LOAD;
            end else if (req1) begin
               sel_d   = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            remaining_d = steps_sel;
            last_d      = sel_q;
            state_d     = (steps_sel == '0) ? DONE : RUN;
         end
         RUN: begin
            // A dropped request ends the job even if this was its last step.
            if (!req_sel) begin
               abort_now   = 1'b1;
               remaining_d = '0;
               state_d     = DONE;
            end else begin
               remaining_d = remaining_q - REM_ONE;
               if (remaining_q == REM_ONE) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (GAP_CYCLES > 0) begin
               gap_d   = GAP_LOAD;
               state_d = GAP;
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (gap_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with the state they describe.
      gnt0_d    = (state_d == LOAD) && !sel_d;
      gnt1_d    = (state_d == LOAD) &&  sel_d;
      done0_d   = (state_d == DONE) && !sel_d;
      done1_d   = (state_d == DONE) &&  sel_d;
      aborted_d = abort_now;
      run_d     = (state_d == RUN);
      busy_d    = (state_d != IDLE);
      wrap_d    = run_q && (cnt_in == 4'd14);
      err_d     = err_q | cnt_in[0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         last_q      <= 1'b1;
         remaining_q <= '0;
         gap_q       <= 4'd0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         aborted_q   <= 1'b0;
         run_q       <= 1'b0;
         busy_q      <= 1'b0;
         wrap_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         remaining_q <= remaining_d;
         gap_q       <= gap_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
         aborted_q   <= aborted_d;
         run_q       <= run_d;
         busy_q      <= busy_d;
         wrap_q      <= wrap_d;
         err_q       <= err_d;
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign aborted = aborted_q;
   assign run     = run_q;
   assign busy    = busy_q;
   assign wrap    = wrap_q;
   assign err     = err_q;

endmodule

// File: tb/tb_even_cnt_sched.sv
// tb/tb_even_cnt_sched.sv - self-checking bench for even_cnt_sched
//
// Purpose:
//    Drives both requesters and models the shared even-step counter, checking
//    grants, run length, done/abort, wrap, err and reset against job-level expectations.
//
// Ports:
//    none (top-level bench)

module tb_even_cnt_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [3:0] steps0 = 4'd0;
   logic [3:0] steps1 = 4'd0;
   logic [3:0] cnt_in = 4'd0;
   logic       cnt_set = 1'b0;
   logic [3:0] cnt_set_val = 4'd0;
   logic       gnt0, gnt1, done0, done1, aborted, run, busy, wrap, err;

   int total = 0;
   int bad = 0;

   even_cnt_sched #(.STEP_W(4), .GAP_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .steps0(steps0), .req1(req1), .steps1(steps1),
      .cnt_in(cnt_in),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .aborted(aborted), .run(run), .busy(busy), .wrap(wrap), .err(err)
   );

   always #5 clk = ~clk;

   // Shared even-step counter: +2 on each edge where run is sampled high.
   always @(posedge clk) begin
      if (cnt_set) cnt_in <= cnt_set_val;
      else if (run) cnt_in <= cnt_in + 4'd2;
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic set_cnt(input logic [3:0] v);
      @(negedge clk);
      cnt_set_val = v; cnt_set = 1'b1;
      @(negedge clk);
      cnt_set = 1'b0;
   endtask

   // Waits (bounded) for the next grant, then follows that job to its done pulse.
   task automatic observe_job(input int drop_after, output int who, output int run_n,
                              output int span, output bit ab, output int wraps,
                              output int wait_n, output bit excl, output bit got);
      int t;
      who = -1; run_n = 0; span = 0; ab = 1'b0; wraps = 0; wait_n = 0; excl = 1'b0; got = 1'b0;
      t = 0;
      while (!(gnt0 || gnt1) && t < 200) begin
         @(negedge clk);
         t++;
      end
      wait_n = t;
      if (!(gnt0 || gnt1)) return;
      if (gnt0 && gnt1) excl = 1'b1;
      who = gnt1 ? 1 : 0;
      t = 0;
      while (t < 100) begin
         @(negedge clk);
         t++;
         if ((gnt0 && gnt1) || (done0 && done1)) excl = 1'b1;
         if (run) run_n++;
         if (wrap) wraps++;
         if (drop_after > 0 && run && run_n == drop_after) begin
            if (who == 0) req0 = 1'b0; else req1 = 1'b0;
         end
         if ((who == 0) ? done0 : done1) begin
            ab = aborted; got = 1'b1; span = t;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [8:0] o;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      o = {gnt0, gnt1, done0, done1, aborted, run, busy, wrap, err};
      total++;
      if (o !== 9'b0) begin bad++; $display("FAIL reset_outputs: got %b want %b", o, 9'b0); end
      rst = 1'b1;
   endtask

   task automatic test_single();
      int who, rn, sp, wr, wn; bit ab, ex, got;
      set_cnt(4'd0);
      steps0 = 4'd3; req0 = 1'b1;
      observe_job(0, who, rn, sp, ab, wr, wn, ex, got);
      req0 = 1'b0;
      total++; if (!got) begin bad++; $display("FAIL single_done: no job completed within bound"); end
      total++; if (who !== 0) begin bad++; $display("FAIL single_who: got %0d want 0", who); end
      total++; if (rn !== 3) begin bad++; $display("FAIL single_run: got %0d want 3", rn); end
      total++; if (sp !== 4) begin bad++; $display("FAIL single_span: got %0d want 4", sp); end
      total++; if (ab !== 1'b0) begin bad++; $display("FAIL single_aborted: got %0d want 0", ab); end
      total++; if (cnt_in !== 4'd6) begin bad++; $display("FAIL single_cnt: got %0d want 6", cnt_in); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int who, rn, sp, wr, wn, exp_cnt; bit ab, ex, got;
      apply_reset();
      set_cnt(4'd0);
      exp_cnt = 0;
      steps0 = 4'd2; steps1 = 4'd2; req0 = 1'b1; req1 = 1'b1;
      for (int j = 0; j < 4; j++) begin
         observe_job(0, who, rn, sp, ab, wr, wn, ex, got);
         if (j == 3) begin req0 = 1'b0; req1 = 1'b0; end
         exp_cnt = (exp_cnt + 4) % 16;
         total++; if (!got) begin bad++; $display("FAIL b2b_done job=%0d: no job completed", j); end
         total++; if (who !== (j % 2)) begin bad++; $display("FAIL b2b_who job=%0d: got %0d want %0d", j, who, j % 2); end
         total++; if (rn !== 2) begin bad++; $display("FAIL b2b_run job=%0d: got %0d want 2", j, rn); end
         total++; if (ex !== 1'b0) begin bad++; $display("FAIL b2b_exclusive job=%0d: gnt or done pair seen together", j); end
         if (j > 0) begin
            total++; if (wn !== 3) begin bad++; $display("FAIL b2b_gap job=%0d: got %0d want 3", j, wn); end
         end
      end
      total++; if (cnt_in !== 4'(exp_cnt)) begin bad++; $display("FAIL b2b_cnt: got %0d want %0d", cnt_in, exp_cnt); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_wrap();
      int who, rn, sp, wr, wn; bit ab, ex, got;
      set_cnt(4'd12);
      steps1 = 4'd3; req1 = 1'b1;
      observe_job(0, who, rn, sp, ab, wr, wn, ex, got);
      req1 = 1'b0;
      total++; if (who !== 1) begin bad++; $display("FAIL wrap_who: got %0d want 1", who); end
      total++; if (wr !== 1) begin bad++; $display("FAIL wrap_count: got %0d want 1", wr); end
      total++; if (cnt_in !== 4'd2) begin bad++; $display("FAIL wrap_cnt: got %0d want 2", cnt_in); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_abort();
      int who, rn, sp, wr, wn; bit ab, ex, got;
      set_cnt(4'd0);
      steps0 = 4'd8; req0 = 1'b1;
      observe_job(3, who, rn, sp, ab, wr, wn, ex, got);
      req0 = 1'b0;
      total++; if (rn !== 3) begin bad++; $display("FAIL abort_run: got %0d want 3", rn); end
      total++; if (ab !== 1'b1) begin bad++; $display("FAIL abort_flag: got %0d want 1", ab); end
      total++; if (sp !== 4) begin bad++; $display("FAIL abort_span: got %0d want 4", sp); end
      total++; if (cnt_in !== 4'd6) begin bad++; $display("FAIL abort_cnt: got %0d want 6", cnt_in); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_zero_steps();
      int who, rn, sp, wr, wn; bit ab, ex, got;
      set_cnt(4'd10);
      steps1 = 4'd0; req1 = 1'b1;
      observe_job(0, who, rn, sp, ab, wr, wn, ex, got);
      req1 = 1'b0;
      total++; if (who !== 1) begin bad++; $display("FAIL zero_who: got %0d want 1", who); end
      total++; if (sp !== 1) begin bad++; $display("FAIL zero_span: got %0d want 1", sp); end
      total++; if (rn !== 0) begin bad++; $display("FAIL zero_run: got %0d want 0", rn); end
      total++; if (cnt_in !== 4'd10) begin bad++; $display("FAIL zero_cnt: got %0d want 10", cnt_in); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      int who, rn, sp, wr, wn, last, model_cnt, exp_who, exp_run, exp_wr, drop, st;
      bit ab, ex, got, pend0, pend1;
      apply_reset();
      model_cnt = 2 * int'($urandom_range(0, 7));
      set_cnt(4'(model_cnt));
      last = 1; pend0 = 1'b0; pend1 = 1'b0;
      for (int it = 0; it < 16; it++) begin
         if (!pend0 && $urandom_range(0, 1) == 1) begin steps0 = 4'($urandom_range(0, 15)); req0 = 1'b1; pend0 = 1'b1; end
         if (!pend1 && $urandom_range(0, 1) == 1) begin steps1 = 4'($urandom_range(0, 15)); req1 = 1'b1; pend1 = 1'b1; end
         if (!pend0 && !pend1) begin steps0 = 4'($urandom_range(0, 15)); req0 = 1'b1; pend0 = 1'b1; end
         exp_who = (pend0 && pend1) ? 1 - last : (pend0 ? 0 : 1);
         st = int'(exp_who == 1 ? steps1 : steps0);
         drop = (st >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, st - 1)) : 0;
         exp_run = (drop > 0) ? drop : st;
         exp_wr = 0;
         for (int k = 0; k < exp_run; k++) if ((model_cnt + 2 * k) % 16 == 14) exp_wr++;
         observe_job(drop, who, rn, sp, ab, wr, wn, ex, got);
         if (exp_who == 0) begin req0 = 1'b0; pend0 = 1'b0; end
         else begin req1 = 1'b0; pend1 = 1'b0; end
         last = exp_who;
         model_cnt = (model_cnt + 2 * exp_run) % 16;
         total++; if (!got) begin bad++; $display("FAIL rand_done it=%0d: no job completed", it); end
         total++; if (who !== exp_who) begin bad++; $display("FAIL rand_who it=%0d: got %0d want %0d", it, who, exp_who); end
         total++; if (rn !== exp_run) begin bad++; $display("FAIL rand_run it=%0d: got %0d want %0d", it, rn, exp_run); end
         total++; if (ab !== (drop > 0)) begin bad++; $display("FAIL rand_aborted it=%0d: got %0d want %0d", it, ab, drop > 0); end
         total++; if (wr !== exp_wr) begin bad++; $display("FAIL rand_wrap it=%0d: got %0d want %0d", it, wr, exp_wr); end
         total++; if (ex !== 1'b0) begin bad++; $display("FAIL rand_exclusive it=%0d: gnt or done pair seen together", it); end
         total++; if (cnt_in !== 4'(model_cnt)) begin bad++; $display("FAIL rand_cnt it=%0d: got %0d want %0d", it, cnt_in, model_cnt); end
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_and_err();
      int who, rn, sp, wr, wn, t; bit ab, ex, got;
      logic [5:0] o;
      set_cnt(4'd0);
      steps0 = 4'd10; req0 = 1'b1;
      t = 0;
      while (!run && t < 50) begin @(negedge clk); t++; end
      total++; if (!run) begin bad++; $display("FAIL midrst_run_seen: run never rose"); end
      #2 rst = 1'b0;
      #1 o = {run, busy, gnt0, gnt1, done0, done1};
      total++; if (o !== 6'b0) begin bad++; $display("FAIL midrst_async: got %b want %b", o, 6'b0); end
      @(negedge clk);
      steps0 = 4'd1; steps1 = 4'd1; req0 = 1'b1; req1 = 1'b1;
      rst = 1'b1;
      observe_job(0, who, rn, sp, ab, wr, wn, ex, got);
      req0 = 1'b0; req1 = 1'b0;
      total++; if (who !== 0) begin bad++; $display("FAIL midrst_first_tie: got %0d want 0", who); end
      repeat (3) @(negedge clk);
      set_cnt(4'd5);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_before: got %0d want 0", err); end
      @(negedge clk);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %0d want 1", err); end
      set_cnt(4'd4);
      repeat (3) @(negedge clk);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0d want 1", err); end
      apply_reset();
      @(negedge clk);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %0d want 0", err); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_abort();
      test_zero_steps();
      test_random();
      test_reset_mid_and_err();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
